// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
// Shared constants and types for the CHIP-8 display path.
//   DISP_W / DISP_H  : framebuffer geometry in pixels
//   DISP_BITS        : framebuffer size in bits (one bit per pixel)
//   FRAME_BYTES      : bytes streamed per frame (8 pixels per byte)
//   stream_state_e   : streamer FSM states
//   pixel_byte()     : picks one byte out of a framebuffer snapshot
// -----------------------------------------------------------------------------
package chip8_pkg;

   localparam int DISP_W      = 64;
   localparam int DISP_H      = 32;
   localparam int DISP_BITS   = DISP_W * DISP_H;
   localparam int FRAME_BYTES = DISP_BITS / 8;
   localparam int IDX_W       = $clog2(FRAME_BYTES);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } stream_state_e;

   // Byte idx covers snapshot bits 8*idx .. 8*idx+7. The lowest bit is the
   // leftmost pixel, which goes out as the MSB (CHIP-8 sprite byte order).
   function automatic logic [7:0] pixel_byte(input logic [DISP_BITS-1:0] snap,
                                             input logic [IDX_W-1:0]     idx);
      logic [7:0] raw;
      logic [7:0] res;
      raw = snap[{idx, 3'b000} +: 8];
      for (int i = 0; i < 8; i++) begin
         res[7-i] = raw[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/chip8_display_streamer.sv
// -----------------------------------------------------------------------------
// chip8_display_streamer
// Streams a snapshot of the 64x32 CHIP-8 framebuffer as 256 bytes over a
// valid/ready interface. The framebuffer is captured when a frame starts, so
// the CPU may keep drawing while the frame is being sent.
//
// Parameters
//   AUTO_START  : 1 = start a frame whenever idle and display differs from
//                 the last captured snapshot
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous reset, active low
//   display     : live framebuffer, pixel (x,y) at display[y*64+x]
//   start       : frame request, sampled only while idle
//   out_data    : pixel byte (leftmost pixel in the MSB)
//   out_valid   : out_data/out_first/out_last are valid
//   out_ready   : sink accepts the current byte
//   out_first   : byte 0 of the frame
//   out_last    : byte 255 of the frame
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last byte is accepted
//   frame_count : completed frames, wraps at 16 bits
//
// States
//   ST_IDLE | waiting for start (or a display change when AUTO_START=1)
//   ST_SEND | presenting snapshot byte idx_q, advancing on each transfer
// -----------------------------------------------------------------------------
module chip8_display_streamer
   import chip8_pkg::*;
#(
   parameter bit AUTO_START = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DISP_BITS-1:0] display,
   input  logic                 start,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 busy,
   output logic                 frame_done,
   output logic [15:0]          frame_count
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   stream_state_e        state_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DISP_BITS-1:0] snap_q;
   logic                 frame_done_q;
   logic [15:0]          frame_count_q;

   logic                 launch;
   logic                 xfer;
   logic [IDX_W-1:0]     idx_d;
   logic [15:0]          frame_count_d;

   // A changed display only launches a frame in auto mode; after reset the
   // snapshot is zero, so any non-blank display counts as a change.
   assign launch        = start | (AUTO_START & (display != snap_q));
   assign xfer          = (state_q == ST_SEND) & out_ready;
   assign idx_d         = idx_q + IDX_W'(1);
   assign frame_count_d = frame_count_q + 16'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         snap_q        <= '0;
         frame_done_q  <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (launch) begin
                  snap_q  <= display;
                  idx_q   <= '0;
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  if (idx_q == LAST_IDX) begin
                     state_q       <= ST_IDLE;
                     idx_q         <= '0;
                     frame_done_q  <= 1'b1;
                     frame_count_q <= frame_count_d;
                  end else begin
                     idx_q <= idx_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Outputs come straight from registered state; the byte itself is a mux
   // off the snapshot, so it cannot move while the sink stalls.
   always_comb begin
      out_valid = (state_q == ST_SEND);
      out_data  = out_valid ? pixel_byte(snap_q, idx_q) : 8'h00;
      out_first = out_valid & (idx_q == '0);
      out_last  = out_valid & (idx_q == LAST_IDX);
   end

   assign busy        = (state_q == ST_SEND);
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_chip8_display_streamer.sv
module tb_chip8_display_streamer;
   import chip8_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset;
   logic [DISP_BITS-1:0] display;
   logic                 start, out_ready;
   logic [7:0]           out_data;
   logic                 out_valid, out_first, out_last, busy, frame_done;
   logic [15:0]          frame_count;

   logic [DISP_BITS-1:0] display_a;
   logic                 start_a, out_ready_a;
   logic [7:0]           out_data_a;
   logic                 out_valid_a, out_first_a, out_last_a, busy_a, frame_done_a;
   logic [15:0]          frame_count_a;

   chip8_display_streamer #(.AUTO_START(1'b0)) dut (
      .clk(clk), .reset(reset), .display(display), .start(start),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_first(out_first), .out_last(out_last), .busy(busy),
      .frame_done(frame_done), .frame_count(frame_count));

   chip8_display_streamer #(.AUTO_START(1'b1)) dut_a (
      .clk(clk), .reset(reset), .display(display_a), .start(start_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_first(out_first_a), .out_last(out_last_a), .busy(busy_a),
      .frame_done(frame_done_a), .frame_count(frame_count_a));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int n);
      checks++;
      errors++;
      $display("FAIL %s timeout after %0d cycles", name, n);
   endtask

   // Reference: byte b is row b/8, pixel columns (b%8)*8 .. +7, leftmost in MSB.
   function automatic logic [7:0] ref_byte(input logic [DISP_BITS-1:0] d, input int b);
      int         y;
      int         x0;
      logic [7:0] r;
      y  = b / (DISP_W / 8);
      x0 = (b % (DISP_W / 8)) * 8;
      for (int k = 0; k < 8; k++) r[7-k] = d[y*DISP_W + x0 + k];
      return r;
   endfunction

   typedef struct {
      logic [7:0] data;
      logic       first;
      logic       last;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   bit          model_busy  = 1'b0;
   bit          exp_done    = 1'b0;
   logic [15:0] model_count = 16'd0;
   int          cyc_cnt     = 0;
   int          last_cycles = 0;

   // Monitor / scoreboard: sampled mid-cycle; inputs only change just after posedge.
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_data",  32'(out_data),  32'd0);
         chk("rst_first", 32'(out_first), 32'd0);
         chk("rst_last",  32'(out_last),  32'd0);
         chk("rst_busy",  32'(busy),      32'd0);
         chk("rst_done",  32'(frame_done), 32'd0);
         chk("rst_count", 32'(frame_count), 32'd0);
         exp_q.delete();
         model_busy  = 1'b0;
         exp_done    = 1'b0;
         model_count = 16'd0;
         cyc_cnt     = 0;
      end else begin
         chk("valid", 32'(out_valid), 32'(model_busy));
         chk("busy",  32'(busy),      32'(model_busy));
         chk("frame_done",  32'(frame_done),  32'(exp_done));
         chk("frame_count", 32'(frame_count), 32'(model_count));
         exp_done = 1'b0;
         if (model_busy) begin
            cyc_cnt++;
            if (exp_q.size() == 0) begin
               timeout("scoreboard_empty", cyc_cnt);
               model_busy = 1'b0;
            end else begin
               e = exp_q[0];
               chk("data",  32'(out_data),  32'(e.data));
               chk("first", 32'(out_first), 32'(e.first));
               chk("last",  32'(out_last),  32'(e.last));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  if (e.last) begin
                     model_busy  = 1'b0;
                     exp_done    = 1'b1;
                     model_count = model_count + 16'd1;
                     last_cycles = cyc_cnt;
                  end
               end
            end
         end else if (start) begin
            for (int b = 0; b < FRAME_BYTES; b++) begin
               e.data  = ref_byte(display, b);
               e.first = (b == 0);
               e.last  = (b == FRAME_BYTES - 1);
               exp_q.push_back(e);
            end
            model_busy = 1'b1;
            cyc_cnt    = 0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((model_busy || out_valid === 1'b1) && n < max) begin
         step(1);
         n++;
      end
      if (n >= max) timeout("wait_idle", n);
   endtask

   task automatic rand_display();
      for (int i = 0; i < DISP_BITS / 32; i++) display[i*32 +: 32] = $urandom();
   endtask

   initial begin
      int n;
      int vcnt;
      reset       = 1'b0;
      start       = 1'b0;
      out_ready   = 1'b0;
      display     = '0;
      start_a     = 1'b0;
      out_ready_a = 1'b1;
      display_a   = '0;
      step(3);
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_busy",  32'(busy), 32'd0);
      chk("reset_count", 32'(frame_count), 32'd0);
      reset = 1'b1;
      step(2);

      // Auto-start instance
      step(10);
      chk("a_no_frame_blank", 32'(out_valid_a), 32'd0);
      display_a[0] = 1'b1;
      step(1);
      chk("a_valid", 32'(out_valid_a), 32'd1);
      chk("a_byte0", 32'(out_data_a), 32'h80);
      chk("a_first", 32'(out_first_a), 32'd1);
      step(10);
      display_a[DISP_BITS-1] = 1'b1;
      n = 0;
      while (frame_done_a !== 1'b1 && n < 400) begin step(1); n++; end
      if (n >= 400) timeout("a_frame1", n);
      chk("a_count1", 32'(frame_count_a), 32'd1);
      n = 0;
      while (!(out_valid_a === 1'b1 && out_last_a === 1'b1) && n < 400) begin step(1); n++; end
      if (n >= 400) timeout("a_frame2", n);
      chk("a_last_byte", 32'(out_data_a), 32'h01);
      step(1);
      chk("a_done2", 32'(frame_done_a), 32'd1);
      chk("a_count2", 32'(frame_count_a), 32'd2);
      chk("a_busy_off", 32'(busy_a), 32'd0);
      vcnt = 0;
      repeat (20) begin step(1); if (out_valid_a) vcnt++; end
      chk("a_no_restart", 32'(vcnt), 32'd0);

      // Single pixel (0,0), sink always ready
      display    = '0;
      display[0] = 1'b1;
      out_ready  = 1'b1;
      pulse_start();
      wait_idle(1000);
      chk("t1_cycles", 32'(last_cycles), 32'd256);
      chk("t1_done",   32'(frame_done), 32'd1);
      chk("t1_count",  32'(frame_count), 32'd1);

      // All ones, sink ready toggling
      display   = '1;
      out_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 511; i++) begin
         out_ready = (i % 2 == 0);
         step(1);
      end
      out_ready = 1'b0;
      wait_idle(50);
      chk("t2_cycles", 32'(last_cycles), 32'd511);
      chk("t2_count",  32'(frame_count), 32'd2);

      // Display change and start pulses mid-frame are ignored
      display   = '0;
      out_ready = 1'b1;
      pulse_start();
      step(10);
      display[DISP_BITS-1] = 1'b1;
      repeat (3) begin
         start = 1'b1;
         step(1);
         start = 1'b0;
         step(5);
      end
      wait_idle(1000);
      chk("t3_count", 32'(frame_count), 32'd3);
      step(5);
      chk("t3_no_queue", 32'(out_valid), 32'd0);

      // Start held: back-to-back frames with a single idle gap
      rand_display();
      out_ready = 1'b1;
      start     = 1'b1;
      step(600);
      start = 1'b0;
      wait_idle(600);

      // Randomized frames
      repeat (6) begin
         rand_display();
         out_ready = 1'($urandom_range(0, 1));
         pulse_start();
         n = 0;
         while ((model_busy || out_valid === 1'b1) && n < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) begin
               int p;
               p = $urandom_range(0, DISP_BITS - 1);
               display[p] = ~display[p];
            end
            step(1);
            n++;
         end
         start = 1'b0;
         if (n >= 3000) timeout("rand_frame", n);
         step(2);
      end
      wait_idle(1000);

      // Reset in the middle of a frame
      rand_display();
      out_ready = 1'b1;
      pulse_start();
      step(100);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_busy",  32'(busy), 32'd0);
      chk("mid_rst_count", 32'(frame_count), 32'd0);
      step(3);
      reset = 1'b1;
      step(2);
      chk("post_rst_idle", 32'(out_valid), 32'd0);
      pulse_start();
      chk("post_rst_first", 32'(out_first), 32'd1);
      wait_idle(1000);
      chk("post_rst_count", 32'(frame_count), 32'd1);

      // Counter wrap
      step(2);
      force dut.frame_count_q = 16'hFFFF;
      #1;
      release dut.frame_count_q;
      model_count = 16'hFFFF;
      rand_display();
      pulse_start();
      wait_idle(1000);
      chk("wrap_done",  32'(frame_done), 32'd1);
      chk("wrap_count", 32'(frame_count), 32'd0);
      step(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
